load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: sits between the execute stage (ALUResult, ReadData2, MemRead, MemWrite, funct3) and the data memory responder.
- Converts one load or store per request into a held, byte-laned memory transaction on a valid/ready handshake.
- Returns sign- or zero-extended load data, holds the core stalled while a transaction is in flight, and flags misaligned, illegal and timed-out accesses.

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per request, held on a valid/ready handshake until mem_ready or timeout.
// Latency: request in N, ready in N+1 -> done in N+2; core stalls while the access is in flight.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [63:0] ALUResult,
  input  logic [63:0] ReadData2,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic [63:0] ReadData,
  output logic        done,
  output logic        stall,
  output logic        fault
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_be;
  logic [2:0]  r_off;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [63:0] r_rdata;
  logic        r_fault;

  logic        w_access;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_bad_req;
  logic        w_timeout;
  logic [7:0]  w_be_base;
  logic [63:0] w_shift;
  logic [63:0] w_load;

  assign w_access  = req_valid & (MemRead | MemWrite);
  assign w_illegal = (MemRead & MemWrite) | (MemWrite & funct3[2]) |
                     (MemRead & (funct3 == 3'b111));
  assign w_bad_req = w_illegal | w_misalign;
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_misalign = 1'b0;
    w_be_base  = 8'h01;
    case (funct3[1:0])
      2'b01: begin w_misalign = ALUResult[0];         w_be_base = 8'h03; end
      2'b10: begin w_misalign = |ALUResult[1:0];      w_be_base = 8'h0F; end
      2'b11: begin w_misalign = |ALUResult[2:0];      w_be_base = 8'hFF; end
      default: begin w_misalign = 1'b0;               w_be_base = 8'h01; end
    endcase
  end

  // Load lane extraction: shift the addressed bytes down, then extend by size.
  assign w_shift = mem_rdata >> {r_off, 3'b000};
  always_comb begin
    w_load = w_shift;
    case (r_size)
      2'b00: w_load = r_uns ? {56'd0, w_shift[7:0]}  : {{56{w_shift[7]}},  w_shift[7:0]};
      2'b01: w_load = r_uns ? {48'd0, w_shift[15:0]} : {{48{w_shift[15]}}, w_shift[15:0]};
      2'b10: w_load = r_uns ? {32'd0, w_shift[31:0]} : {{32{w_shift[31]}}, w_shift[31:0]};
      default: w_load = w_shift;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_access) w_next = w_bad_req ? S_DONE : S_WAIT;
      S_WAIT: if (mem_ready || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 8'd0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_addr      <= 64'd0;
      r_wdata     <= 64'd0;
      r_be        <= 8'd0;
      r_off       <= 3'd0;
      r_size      <= 2'd0;
      r_uns       <= 1'b0;
      r_rdata     <= 64'd0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_fault <= w_access & w_bad_req;
          if (w_access && !w_bad_req) begin
            r_addr      <= {ALUResult[63:3], 3'b000};
            r_off       <= ALUResult[2:0];
            r_size      <= funct3[1:0];
            r_uns       <= funct3[2];
            r_be        <= w_be_base << ALUResult[2:0];
            r_wdata     <= ReadData2 << {ALUResult[2:0], 3'b000};
            r_mem_read  <= MemRead;
            r_mem_write <= MemWrite;
            r_cnt       <= 8'd0;
          end
        end
        S_WAIT: begin
          // Ready on the threshold cycle wins over the timeout.
          if (mem_ready) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_mem_read) r_rdata <= w_load;
          end else if (w_timeout) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_fault     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_fault <= 1'b0;
      endcase
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign ReadData  = r_rdata;
  assign done      = (r_state == S_DONE);
  assign fault     = r_fault;
  assign stall     = reset & (((r_state == S_IDLE) & w_access) | (r_state == S_WAIT));

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single accesses plus reset and idle corner sequences.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [63:0] ALUResult, ReadData2;
  logic        mem_read, mem_write;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_be;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic [63:0] ReadData;
  logic        done, stall, fault;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .ReadData2(ReadData2),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ReadData(ReadData), .done(done), .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  // delay: -1 = rejected at request, 0 = never ready (timeout), n = ready in n-th wait cycle
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] rdata;
    int          delay;
    logic [63:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input int idx, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int n;
    req_valid = 1'b1; MemRead = v.rd; MemWrite = v.wr; funct3 = v.f3;
    ALUResult = v.addr; ReadData2 = v.wd; mem_rdata = v.rdata; mem_ready = 1'b0;
    #1 chk(idx, "stall_on_req", stall, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    if (v.delay < 0) begin
      chk(idx, "rej_mem_read", mem_read, 0);
      chk(idx, "rej_mem_write", mem_write, 0);
      chk(idx, "rej_stall", stall, 0);
    end else begin
      n = (v.delay == 0) ? TMO : v.delay;
      for (int k = 1; k <= n; k++) begin
        chk(idx, "wait_mem_read", mem_read, v.rd);
        chk(idx, "wait_mem_write", mem_write, v.wr);
        chk(idx, "wait_stall", stall, 1);
        chk(idx, "wait_done", done, 0);
        chk(idx, "mem_addr", mem_addr, v.e_addr);
        chk(idx, "mem_be", mem_be, v.e_be);
        chk(idx, "mem_wdata", mem_wdata, v.e_wdata);
        if (k == v.delay) mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
      end
    end
    chk(idx, "done", done, 1);
    chk(idx, "fault", fault, (v.delay <= 0) ? 1 : 0);
    chk(idx, "ReadData", ReadData, v.e_rdata);
    chk(idx, "done_mem_read", mem_read, 0);
    chk(idx, "done_mem_write", mem_write, 0);
    chk(idx, "done_stall", stall, 0);
    @(posedge clk); #1;
    chk(idx, "done_pulse_end", done, 0);
    chk(idx, "fault_clear", fault, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //          rd wr f3      addr     wd                     rdata                    dly e_addr   e_be   e_wdata                e_rdata
    vecs[0]  = '{1, 0, 3'b010, 64'h14,   64'h0,                64'h80000001_00000000, 1,  64'h10,   8'hF0, 64'h0,                64'hFFFFFFFF_80000001};
    vecs[1]  = '{0, 1, 3'b000, 64'h23,   64'hAB,               64'h0,                 3,  64'h20,   8'h08, 64'h00000000_AB000000, 64'hFFFFFFFF_80000001};
    vecs[2]  = '{1, 0, 3'b101, 64'h6,    64'h0,                64'hFFFE0000_00000000, 1,  64'h0,    8'hC0, 64'h0,                64'h00000000_0000FFFE};
    vecs[3]  = '{1, 0, 3'b011, 64'h4,    64'h0,                64'h0,                 -1, 64'h0,    8'h00, 64'h0,                64'h00000000_0000FFFE};
    vecs[4]  = '{1, 0, 3'b000, 64'h1001, 64'h0,                64'h00000000_00008000, 2,  64'h1000, 8'h02, 64'h0,                64'hFFFFFFFF_FFFFFF80};
    vecs[5]  = '{1, 0, 3'b011, 64'h38,   64'h0,                64'h01234567_89ABCDEF, 1,  64'h38,   8'hFF, 64'h0,                64'h01234567_89ABCDEF};
    vecs[6]  = '{0, 1, 3'b010, 64'h44,   64'h11223344,         64'h0,                 2,  64'h40,   8'hF0, 64'h11223344_00000000, 64'h01234567_89ABCDEF};
    vecs[7]  = '{0, 1, 3'b011, 64'h08,   64'hDEADBEEF_CAFEF00D, 64'h0,                1,  64'h08,   8'hFF, 64'hDEADBEEF_CAFEF00D, 64'h01234567_89ABCDEF};
    vecs[8]  = '{0, 1, 3'b100, 64'h0,    64'h55,               64'h0,                 -1, 64'h0,    8'h00, 64'h0,                64'h01234567_89ABCDEF};
    vecs[9]  = '{1, 1, 3'b010, 64'h10,   64'h55,               64'h0,                 -1, 64'h0,    8'h00, 64'h0,                64'h01234567_89ABCDEF};
    vecs[10] = '{1, 0, 3'b111, 64'h10,   64'h0,                64'h0,                 -1, 64'h0,    8'h00, 64'h0,                64'h01234567_89ABCDEF};
    vecs[11] = '{0, 1, 3'b001, 64'h3,    64'hBEEF,             64'h0,                 -1, 64'h0,    8'h00, 64'h0,                64'h01234567_89ABCDEF};
    vecs[12] = '{1, 0, 3'b001, 64'h2,    64'h0,                64'h00000000_7FFF0000, 4,  64'h0,    8'h0C, 64'h0,                64'h00000000_00007FFF};
    vecs[13] = '{0, 1, 3'b010, 64'h50,   64'h5,                64'h0,                 0,  64'h50,   8'h0F, 64'h5,                64'h00000000_00007FFF};
    vecs[14] = '{1, 0, 3'b010, 64'h60,   64'h0,                64'hFFFFFFFF_FFFFFFFF, 0,  64'h60,   8'h0F, 64'h0,                64'h00000000_00007FFF};
    vecs[15] = '{1, 0, 3'b110, 64'h1C,   64'h0,                64'hF0000000_00000000, 1,  64'h18,   8'hF0, 64'h0,                64'h00000000_F0000000};

    reset = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUResult = 64'h0; ReadData2 = 64'h0; mem_rdata = 64'h0; mem_ready = 1'b0;
    #1;
    chk(-1, "rst_mem_read", mem_read, 0);
    chk(-1, "rst_mem_write", mem_write, 0);
    chk(-1, "rst_mem_addr", mem_addr, 0);
    chk(-1, "rst_mem_be", mem_be, 0);
    chk(-1, "rst_ReadData", ReadData, 0);
    chk(-1, "rst_done", done, 0);
    chk(-1, "rst_stall", stall, 0);
    chk(-1, "rst_fault", fault, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Request with neither strobe, plus a stray mem_ready in IDLE: nothing happens.
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b1;
    #1 chk(100, "nop_stall", stall, 0);
    idle_cycle();
    chk(100, "nop_mem_read", mem_read, 0);
    chk(100, "nop_mem_write", mem_write, 0);
    chk(100, "nop_done", done, 0);
    req_valid = 1'b0; mem_ready = 1'b0;
    idle_cycle();

    // Reset dropped mid-WAIT.
    req_valid = 1'b1; MemRead = 1'b1; funct3 = 3'b011; ALUResult = 64'h40;
    @(posedge clk); #1;
    req_valid = 1'b0; MemRead = 1'b0;
    chk(101, "pre_rst_mem_read", mem_read, 1);
    #2 reset = 1'b0;
    #1;
    chk(101, "mid_rst_mem_read", mem_read, 0);
    chk(101, "mid_rst_stall", stall, 0);
    chk(101, "mid_rst_done", done, 0);
    chk(101, "mid_rst_ReadData", ReadData, 0);
    @(posedge clk); #1;
    chk(101, "in_rst_done", done, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk(101, "post_rst_done", done, 0);
    v = '{1, 0, 3'b100, 64'h7, 64'h0, 64'hA5000000_00000000, 1, 64'h0, 8'h80, 64'h0, 64'h00000000_000000A5};
    run_vec(102, v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
